// File: rtl/skin_bbox_detect.sv
// Skin-tone classifier for the gesture pipeline. It thresholds Cb/Cr to produce a binary image one
// cycle later, and it latches each frame's skin bounding box and pixel count at the vsync rising edge.
module skin_bbox_detect #(
  parameter int H_W        = 11,
  parameter int V_W        = 11,
  parameter int CNT_W      = 20,
  parameter int CB_MIN     = 77,
  parameter int CB_MAX     = 127,
  parameter int CR_MIN     = 133,
  parameter int CR_MAX     = 173,
  parameter int MIN_PIXELS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ycbcr_vsync,
  input  logic             ycbcr_clken,
  input  logic             ycbcr_valid,
  input  logic [23:0]      ycbcr_data,
  output logic             bin_vsync,
  output logic             bin_clken,
  output logic             bin_valid,
  output logic [23:0]      bin_data,
  output logic             frame_done,
  output logic             box_valid,
  output logic [H_W-1:0]   box_x_min,
  output logic [H_W-1:0]   box_x_max,
  output logic [V_W-1:0]   box_y_min,
  output logic [V_W-1:0]   box_y_max,
  output logic [CNT_W-1:0] skin_cnt
);

  localparam logic [7:0]       CB_LO   = 8'(CB_MIN);
  localparam logic [7:0]       CB_HI   = 8'(CB_MAX);
  localparam logic [7:0]       CR_LO   = 8'(CR_MIN);
  localparam logic [7:0]       CR_HI   = 8'(CR_MAX);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);
  localparam logic [H_W-1:0]   X_ONES  = '1;
  localparam logic [V_W-1:0]   Y_ONES  = '1;
  localparam logic [CNT_W-1:0] C_ONES  = '1;

  logic [7:0] cb, cr;
  logic       accepted, is_skin, frame_start, line_end;
  logic       unused_luma;

  logic             bin_vsync_q,  bin_vsync_d;
  logic             bin_clken_q,  bin_clken_d;
  logic             bin_valid_q,  bin_valid_d;
  logic [23:0]      bin_data_q,   bin_data_d;
  logic             frame_done_q, frame_done_d;
  logic             box_valid_q,  box_valid_d;
  logic [H_W-1:0]   box_x_min_q,  box_x_min_d;
  logic [H_W-1:0]   box_x_max_q,  box_x_max_d;
  logic [V_W-1:0]   box_y_min_q,  box_y_min_d;
  logic [V_W-1:0]   box_y_max_q,  box_y_max_d;
  logic [CNT_W-1:0] skin_cnt_q,   skin_cnt_d;
  logic [H_W-1:0]   x_q,          x_d;
  logic [V_W-1:0]   y_q,          y_d;
  logic [CNT_W-1:0] run_cnt_q,    run_cnt_d;
  logic [H_W-1:0]   run_x_min_q,  run_x_min_d;
  logic [H_W-1:0]   run_x_max_q,  run_x_max_d;
  logic [V_W-1:0]   run_y_min_q,  run_y_min_d;
  logic [V_W-1:0]   run_y_max_q,  run_y_max_d;

  // Luma does not take part in the skin decision.
  assign unused_luma = ^ycbcr_data[23:16];
  assign cb          = ycbcr_data[15:8];
  assign cr          = ycbcr_data[7:0];

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can infer a latch.
    bin_vsync_d  = ycbcr_vsync;
    bin_clken_d  = ycbcr_clken;
    bin_valid_d  = ycbcr_valid;
    box_valid_d  = box_valid_q;
    box_x_min_d  = box_x_min_q;
    box_x_max_d  = box_x_max_q;
    box_y_min_d  = box_y_min_q;
    box_y_max_d  = box_y_max_q;
    skin_cnt_d   = skin_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    run_cnt_d    = run_cnt_q;
    run_x_min_d  = run_x_min_q;
    run_x_max_d  = run_x_max_q;
    run_y_min_d  = run_y_min_q;
    run_y_max_d  = run_y_max_q;

    accepted     = ycbcr_clken && ycbcr_valid;
    is_skin      = accepted && (cb >= CB_LO) && (cb <= CB_HI) && (cr >= CR_LO) && (cr <= CR_HI);
    frame_start  = ycbcr_vsync && !bin_vsync_q;
    line_end     = bin_valid_q && !ycbcr_valid;
    bin_data_d   = is_skin ? 24'hFFFFFF : 24'h000000;
    frame_done_d = frame_start;

    if (frame_start) begin
      // The pixel in this cycle (if any) is binarized only and belongs to neither frame.
      skin_cnt_d = run_cnt_q;
      if (run_cnt_q >= MIN_CNT) begin
        box_valid_d = 1'b1;
        box_x_min_d = run_x_min_q;
        box_x_max_d = run_x_max_q;
        box_y_min_d = run_y_min_q;
        box_y_max_d = run_y_max_q;
      end else begin
        box_valid_d = 1'b0;
        box_x_min_d = '0;
        box_x_max_d = '0;
        box_y_min_d = '0;
        box_y_max_d = '0;
      end
      x_d         = '0;
      y_d         = '0;
      run_cnt_d   = '0;
      run_x_min_d = '1;
      run_x_max_d = '0;
      run_y_min_d = '1;
      run_y_max_d = '0;
    end else begin
      if (line_end) begin
        x_d = '0;
        if (y_q != Y_ONES) y_d = y_q + V_W'(1);
      end else if (accepted && (x_q != X_ONES)) begin
        x_d = x_q + H_W'(1);
      end
      if (is_skin) begin
        if (x_q < run_x_min_q) run_x_min_d = x_q;
        if (x_q > run_x_max_q) run_x_max_d = x_q;
        if (y_q < run_y_min_q) run_y_min_d = y_q;
        if (y_q > run_y_max_q) run_y_max_d = y_q;
        if (run_cnt_q != C_ONES) run_cnt_d = run_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      bin_vsync_q  <= 1'b0;
      bin_clken_q  <= 1'b0;
      bin_valid_q  <= 1'b0;
      bin_data_q   <= '0;
      frame_done_q <= 1'b0;
      box_valid_q  <= 1'b0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      skin_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      run_cnt_q    <= '0;
      run_x_min_q  <= '1;
      run_x_max_q  <= '0;
      run_y_min_q  <= '1;
      run_y_max_q  <= '0;
    end else begin
      bin_vsync_q  <= bin_vsync_d;
      bin_clken_q  <= bin_clken_d;
      bin_valid_q  <= bin_valid_d;
      bin_data_q   <= bin_data_d;
      frame_done_q <= frame_done_d;
      box_valid_q  <= box_valid_d;
      box_x_min_q  <= box_x_min_d;
      box_x_max_q  <= box_x_max_d;
      box_y_min_q  <= box_y_min_d;
      box_y_max_q  <= box_y_max_d;
      skin_cnt_q   <= skin_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      run_cnt_q    <= run_cnt_d;
      run_x_min_q  <= run_x_min_d;
      run_x_max_q  <= run_x_max_d;
      run_y_min_q  <= run_y_min_d;
      run_y_max_q  <= run_y_max_d;
    end
  end

  assign bin_vsync  = bin_vsync_q;
  assign bin_clken  = bin_clken_q;
  assign bin_valid  = bin_valid_q;
  assign bin_data   = bin_data_q;
  assign frame_done = frame_done_q;
  assign box_valid  = box_valid_q;
  assign box_x_min  = box_x_min_q;
  assign box_x_max  = box_x_max_q;
  assign box_y_min  = box_y_min_q;
  assign box_y_max  = box_y_max_q;
  assign skin_cnt   = skin_cnt_q;

endmodule

// File: doc/skin_bbox_detect.md
Name: skin_bbox_detect

Overview:
- Sits directly downstream of the RGB-to-YCbCr converter in the gesture pipeline.
- Consumes its packed {Y,Cb,Cr} stream plus vsync/clken/valid.
- Classifies each pixel as skin or non-skin by Cb/Cr window and emits a 1-cycle-delayed binary image stream.
- Accumulates per-frame skin bounding box and skin pixel count, which are latched at each frame boundary for the gesture logic.

Parameters:
- H_W, 11, column counter / coordinate width
- V_W, 11, row counter / coordinate width
- CNT_W, 20, skin pixel count width
- CB_MIN, 77, lower Cb bound (inclusive)
- CB_MAX, 127, upper Cb bound (inclusive)
- CR_MIN, 133, lower Cr bound (inclusive)
- CR_MAX, 173, upper Cr bound (inclusive)
- MIN_PIXELS, 64, minimum skin count for a frame's box to be flagged valid

Ports:
- clk  in  1  module clock
- rst_n  in  1  reset, synchronous, active-low
- ycbcr_vsync  in  1  frame sync; rising edge = frame boundary
- ycbcr_clken  in  1  clock enable
- ycbcr_valid  in  1  pixel valid; high for the active part of each line
- ycbcr_data  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- bin_vsync  out  1  ycbcr_vsync delayed 1 cycle
- bin_clken  out  1  ycbcr_clken delayed 1 cycle
- bin_valid  out  1  ycbcr_valid delayed 1 cycle
- bin_data  out  24  24'hFFFFFF for skin, 24'h000000 otherwise
- frame_done  out  1  one-cycle pulse when box outputs update
- box_valid  out  1  last frame had count >= MIN_PIXELS
- box_x_min  out  H_W  latched box left column
- box_x_max  out  H_W  latched box right column
- box_y_min  out  V_W  latched box top row
- box_y_max  out  V_W  latched box bottom row
- skin_cnt  out  CNT_W  latched skin pixel count

Behaviour:
- Reset, synchronous on rising clk with rst_n=0: all outputs 0. x/y counters 0. Running count 0. Running min registers all-ones, max registers 0. Edge-detect registers 0.
- Reset mid-frame discards the partial frame. Statistics restart at the next vsync rising edge; pixels between reset release and that edge are counted from x=0, y=0.
- Accepted pixel: ycbcr_clken && ycbcr_valid.
- skin = accepted && CB_MIN <= Cb <= CB_MAX && CR_MIN <= Cr <= CR_MAX, using unsigned 8-bit compares.
- Binary path latency is exactly 1 cycle. bin_data = skin ? 24'hFFFFFF : 0. bin_data is 0 whenever the pixel is not accepted.
- Column counter x: holds the column of the current accepted pixel and increments after each accepted pixel. It clears to 0 on the valid falling edge (registered valid=1, current valid=0), and that same edge increments row counter y.
- x and y saturate at all-ones and do not wrap.
- For a skin pixel at (x,y):
  - run_x_min = min(run_x_min, x)
  - run_x_max = max(run_x_max, x)
  - likewise for y
  - run_cnt += 1, saturating at 2^CNT_W-1
- Frame boundary is the cycle in which vsync is 1 and registered vsync is 0. In that cycle, the following happens next edge:
  - skin_cnt <= run_cnt.
  - If run_cnt >= MIN_PIXELS: box_valid <= 1 and box_* <= run_*.
  - Otherwise: box_valid <= 0 and box_* <= 0.
  - frame_done <= 1 for exactly 1 cycle.
  - x, y, run_cnt clear; mins go to all-ones; maxes go to 0.
- A pixel accepted in the boundary cycle itself is still binarized but excluded from both the closing and the new frame statistics.
- Latched box outputs hold their values between frame_done pulses.
- A frame with no skin pixels gives skin_cnt=0, box_valid=0, box_* = 0.
- Consecutive vsync rising edges with no pixels between them still produce a frame_done pulse.

Test Plan:
- Reset then a single pixel {Y=8'h80, Cb=100, Cr=150}, clken=valid=1 -> next cycle bin_data=24'hFFFFFF, bin_valid=1. One cycle earlier with rst_n=0, all outputs are 0.
- Boundary Cb values: Cb=76,77,127,128 with Cr=150 -> bin_data pattern 0, FFFFFF, FFFFFF, 0. Same check for Cr=132,133,173,174 with Cb=100.
- 16x8 frame, MIN_PIXELS=4, skin block at columns 3..6, rows 2..4 (12 pixels), then vsync rise -> frame_done single pulse, box_valid=1, x_min=3, x_max=6, y_min=2, y_max=4, skin_cnt=12.
- Same 16x8 frame with only 3 skin pixels -> box_valid=0, box_*=0, skin_cnt=3. Previous latched values are overwritten on this frame_done.
- clken toggled 0 on alternate cycles during a line -> gated cycles are not counted: a skin pixel at the 5th accepted position reports x=4.
- rst_n=0 for 2 cycles mid-frame after 20 skin pixels -> outputs 0. The next frame reports only the post-reset skin count. No frame_done is produced during reset.
